muldiv_hilo_unit: RTL and testbench

- Multi-cycle multiply/divide responder that owns the architectural HI/LO registers.
- Execute-stage ALU issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests to it, and reads HI/LO back for MFHI/MFLO.
- Iterative radix-2 datapath: one partial product or quotient bit per cycle.
- Exposes busy/stall status so the pipeline holds MFHI/MFLO and new mul/div issues until results are committed.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_iter_core.sv | 66 ++++++
 rtl/muldiv_hilo_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: func codes, FSM states, op kinds.
package muldiv_pkg;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;
  typedef enum logic {OP_MUL, OP_DIV} op_kind_e;
endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath: unsigned shift-add multiply / restoring divide, one bit per cycle.
module muldiv_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               flush,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               last
);
  // acc holds {upper, lower}: mul = {partial sum, remaining multiplier}, div = {remainder, quotient}
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   opb;
  logic [CNT_W-1:0]   cnt;
  logic               running, div_mode;
  logic [WIDTH:0]     sum, shl;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    shl  = acc[2*WIDTH-1:WIDTH-1];
    ge   = shl >= {1'b0, opb};
    diff = shl[WIDTH-1:0] - opb;
    if (div_mode)
      acc_nx = {(ge ? diff : shl[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    else if (acc[0])
      acc_nx = {sum, acc[WIDTH-1:1]};
    else
      acc_nx = {1'b0, acc[2*WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      opb      <= is_div ? mag_b : mag_a;
      cnt      <= CNT_W'(WIDTH - 1);
      running  <= 1'b1;
      div_mode <= is_div;
    end else if (flush) begin
      running <= 1'b0;
    end else if (running) begin
      acc <= acc_nx;
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign last      = running && (cnt == '0);
  assign product   = acc;
  assign quotient  = acc[WIDTH-1:0];
  assign remainder = acc[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO owner: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the iterative core, commits on FIX.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             rd_hi_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  state_e             state, state_nx;
  op_kind_e           kind;
  logic               sgn, neg_q, neg_r, dz;
  logic [WIDTH-1:0]   a_q, b_q, hi, lo, mag_a, mag_b;
  logic               accept, is_md, dz_now, start, last;
  logic [2*WIDTH-1:0] product, prod_s;
  logic [WIDTH-1:0]   quotient, remainder, q_s, r_s;

  assign req_ready = (state == IDLE) && !abort;
  assign accept    = req_valid && req_ready;
  assign is_md     = (req_func == MULT) || (req_func == MULTU) ||
                     (req_func == DIV)  || (req_func == DIVU);
  assign dz_now    = (kind == OP_DIV) && (b_q == '0);
  // two's-complement negate maps the most negative value onto its own unsigned magnitude
  assign mag_a     = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign start     = (state == PREP) && !abort && !dz_now;

  muldiv_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .flush     (abort),
    .is_div    (kind == OP_DIV),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && is_md) state_nx = PREP;
      PREP: state_nx = dz_now ? FIX : CALC;
      CALC: if (last) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  assign prod_s = neg_q ? -product : product;
  assign q_s    = neg_q ? -quotient : quotient;
  assign r_s    = neg_r ? -remainder : remainder;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind  <= OP_MUL;
      sgn   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept && is_md) begin
        a_q  <= rs_data;
        b_q  <= rt_data;
        kind <= ((req_func == DIV) || (req_func == DIVU)) ? OP_DIV : OP_MUL;
        sgn  <= (req_func == MULT) || (req_func == DIV);
      end
      if (state == PREP) begin
        neg_q <= sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_r <= sgn && a_q[WIDTH-1];
        dz    <= dz_now;
      end
      if (accept && (req_func == MTHI)) hi <= rs_data;
      if (accept && (req_func == MTLO)) lo <= rs_data;
      if (state == FIX && !abort) begin
        if (dz) begin
          lo <= '1;
          hi <= a_q;
        end else if (kind == OP_MUL) begin
          {hi, lo} <= prod_s;
        end else begin
          lo <= q_s;
          hi <= r_s;
        end
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FIX) && !abort;
  assign hi_out  = hi;
  assign lo_out  = lo;
  assign rd_data = rd_hi_sel ? hi : lo;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomized + directed bench for muldiv_hilo_unit against an arithmetic HI/LO model.
module tb_muldiv_hilo_unit;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MTHI = 6'b010001, F_MTLO = 6'b010011;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, abort = 1'b0, busy, done, rd_hi_sel = 1'b0;
  logic [5:0]  req_func = '0;
  logic [31:0] rs_data = '0, rt_data = '0, rd_data, hi_out, lo_out;

  int checks = 0, failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clock = ~clock;

  muldiv_hilo_unit dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .rs_data(rs_data), .rt_data(rt_data), .abort(abort),
    .busy(busy), .done(done), .rd_hi_sel(rd_hi_sel), .rd_data(rd_data),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero like MIPS DIV.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = m_hi; el = m_lo; lat = 0;
    case (f)
      F_MULT:  begin sp = sa * sb; {eh, el} = sp; lat = 34; end
      F_MULTU: begin up = {32'b0, a} * {32'b0, b}; {eh, el} = up; lat = 34; end
      F_DIV, F_DIVU: begin
        if (b == 0) begin el = 32'hFFFFFFFF; eh = a; lat = 2; end
        else if (f == F_DIV) begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; lat = 34; end
        else begin el = a / b; eh = a % b; lat = 34; end
      end
      F_MTHI: eh = a;
      F_MTLO: el = a;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, hi_out, m_hi);
    chk({tag, "_lo"}, lo_out, m_lo);
    rd_hi_sel = 1'b1; #1 chk({tag, "_rdhi"}, rd_data, m_hi);
    rd_hi_sel = 1'b0; #1 chk({tag, "_rdlo"}, rd_data, m_lo);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int lat, nd, exp_lat;
    model(f, a, b, eh, el, exp_lat);
    @(negedge clock);
    req_valid = 1'b1; req_func = f; rs_data = a; rt_data = b;
    #1 chk({tag, "_ready"}, req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0; rs_data = $urandom; rt_data = $urandom;
    lat = 0; nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) nd++;
      if (!busy) break;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_done"}, nd, (exp_lat != 0) ? 1 : 0);
    m_hi = eh; m_lo = el;
    check_regs(tag);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    req_valid = 1'b1; req_func = f; rs_data = a; rt_data = b;
    @(posedge clock); #1 req_valid = 1'b0;
  endtask

  initial begin
    int bad, nd;
    logic [5:0] fl [7] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'b100000};
    logic [31:0] a, b;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 1);
    check_regs("rst");
    @(negedge clock); reset_n = 1'b1;

    run_op("mult",   F_MULT,  32'hFFFFFFFF, 32'h2);
    run_op("multu",  F_MULTU, 32'hFFFFFFFF, 32'h2);
    run_op("div",    F_DIV,   32'hFFFFFFF9, 32'h2);
    run_op("divu",   F_DIVU,  32'd100,      32'd7);
    run_op("divu0",  F_DIVU,  32'h12345678, 32'h0);
    run_op("div0",   F_DIV,   32'h87654321, 32'h0);
    run_op("divovf", F_DIV,   32'h80000000, 32'hFFFFFFFF);
    run_op("multmn", F_MULT,  32'h80000000, 32'h80000000);
    run_op("mthi",   F_MTHI,  32'hCAFEBABE, 32'h0);
    run_op("mtlo",   F_MTLO,  32'h0BADF00D, 32'h0);
    run_op("nop",    6'b100000, 32'h1, 32'h1);

    // request held while busy must not be accepted until the unit returns to IDLE
    issue(F_DIVU, 32'd100, 32'd7);
    req_valid = 1'b1; req_func = F_MTLO; rs_data = 32'h0BADF00D;
    bad = 0; nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) nd++;
      if (!busy) break;
      if (req_ready) bad++;
    end
    chk("hold_ready_busy", bad, 0);
    chk("hold_done", nd, 1);
    chk("hold_ready_idle", req_ready, 1);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    m_hi = 32'd2; m_lo = 32'h0BADF00D;
    check_regs("hold");

    // abort on busy cycle 10
    run_op("pre_hi", F_MTHI, 32'h11, 32'h0);
    run_op("pre_lo", F_MTLO, 32'h22, 32'h0);
    issue(F_MULT, 32'd3, 32'd5);
    nd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    @(negedge clock);
    chk("abort_done", nd + int'(done), 0);
    check_regs("abort");

    // abort coincident with the FIX cycle suppresses the commit
    issue(F_MULT, 32'd3, 32'd5);
    for (int i = 1; i <= 34; i++) @(negedge clock);
    chk("fix_done_pre", done, 1);
    abort = 1'b1;
    #1 chk("fix_done_abort", done, 0);
    @(posedge clock); #1 abort = 1'b0;
    chk("fix_abort_busy", busy, 0);
    check_regs("fixabort");

    // abort with req_valid in IDLE: not accepted
    @(negedge clock);
    abort = 1'b1; req_valid = 1'b1; req_func = F_MTHI; rs_data = 32'hDEADBEEF;
    #1 chk("abort_idle_ready", req_ready, 0);
    @(posedge clock); #1 begin abort = 1'b0; req_valid = 1'b0; end
    chk("abort_idle_busy", busy, 0);
    check_regs("abortidle");

    // asynchronous reset mid-CALC
    issue(F_MULT, 32'h1234, 32'h5678);
    for (int i = 0; i < 10; i++) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi_out, 0);
    chk("arst_lo", lo_out, 0);
    @(negedge clock); reset_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op("post_rst", F_MULTU, 32'd7, 32'd6);

    for (int n = 0; n < 30; n++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op("rand", fl[$urandom_range(0, 6)], a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
